hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. It drives the stall and flush controls of the F/D, D/E, E/M and M/W pipeline registers and selects the E-stage operand forwarding sources from the M and W stages. It also runs a small FSM that freezes the whole pipeline while a data-memory access is outstanding, with a wait watchdog. It sits beside the datapath and consumes register addresses and control bits from the D, E, M and W stages.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_unit_if.sv | 33 +++
 rtl/forward_sel.sv | 21 ++
 rtl/hazard_unit.sv | 102 ++++++++++
 tb/tb_hazard_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  : E-stage operand source select (regfile / W result / M ALU result)
//   hz_state_t : memory-wait FSM states
//   REG_AW     : register-address width
//   src_hit()  : "this producer writes the register this consumer reads" (x0 excluded)
package hazard_pkg;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  function automatic logic src_hit(input logic we,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: stage-side bundle between the datapath and the hazard unit.
//   master : datapath side, drives register addresses / control bits, reads controls
//   slave  : hazard unit side, reads stage info, drives forwarding/stall/flush/timeout
interface hazard_unit_if;
  import hazard_pkg::*;

  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic              ResultSrcE, PCSrcE;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM, MemReqM, MemReadyM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW;

  fwd_sel_t          ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic              MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemTimeout
  );
endinterface

// File: rtl/forward_sel.sv
// forward_sel: per-operand forwarding priority (pure combinational).
//   rs            : E-stage source register
//   rd_m/we_m     : M-stage destination / write enable (highest priority)
//   rd_w/we_w     : W-stage destination / write enable
//   sel           : FWD_M, FWD_W or FWD_REG; x0 never forwards
module forward_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              we_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              we_w,
  output fwd_sel_t          sel
);
  always_comb begin
    sel = FWD_REG;
    if (src_hit(we_m, rd_m, rs))      sel = FWD_M;  // youngest value wins
    else if (src_hit(we_w, rd_w, rs)) sel = FWD_W;
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding controller for the five-stage core, plus a
// memory-wait FSM that freezes the pipeline while a data access is outstanding.
//   clk, rst        : clock, synchronous active-high reset
//   hz (slave)      : stage register addresses/control in, forward/stall/flush/timeout out
//   LoadStallCnt,
//   RedirectCnt,
//   MemWaitCnt      : saturating event counters, present only with HAZARD_PERF_EN
// Parameters: DATA_WIDTH (perf counter width), MAX_WAIT (watchdog threshold, >=1).
// Optional feature macro: HAZARD_PERF_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_unit_if.slave          hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] LoadStallCnt,
  output logic [DATA_WIDTH-1:0] RedirectCnt,
  output logic [DATA_WIDTH-1:0] MemWaitCnt
`endif
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  hz_state_t state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          timeout;
  fwd_sel_t      fwd_a, fwd_b;
  logic          lu, rd, freeze, lu_resp, rd_resp;

  forward_sel u_fwd_a (.rs(hz.Rs1E), .rd_m(hz.RdM), .we_m(hz.RegWriteM),
                       .rd_w(hz.RdW), .we_w(hz.RegWriteW), .sel(fwd_a));
  forward_sel u_fwd_b (.rs(hz.Rs2E), .rd_m(hz.RdM), .we_m(hz.RegWriteM),
                       .rd_w(hz.RdW), .we_w(hz.RegWriteW), .sel(fwd_b));

  always_comb begin
    lu = hz.ResultSrcE && (hz.RdE != '0) && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    rd = hz.PCSrcE;
    // The entering RUN cycle freezes too, so nothing advances under a missed access.
    freeze  = !rst && ((state == MEM_WAIT) || (hz.MemReqM && !hz.MemReadyM));
    // Frozen E re-presents on release, so masking here loses no event.
    // Redirect discards the D instruction, so its load-use stall is moot.
    rd_resp = !rst && !freeze && rd;
    lu_resp = !rst && !freeze && lu && !rd;
  end

  always_comb begin
    hz.ForwardAE  = rst ? FWD_REG : fwd_a;
    hz.ForwardBE  = rst ? FWD_REG : fwd_b;
    hz.StallF     = freeze || lu_resp;
    hz.StallD     = freeze || lu_resp;
    hz.StallE     = freeze;
    hz.StallM     = freeze;
    hz.FlushD     = rst || rd_resp;
    hz.FlushE     = rst || rd_resp || lu_resp;
    hz.FlushW     = rst || freeze;
    hz.MemTimeout = timeout;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (hz.MemReqM && !hz.MemReadyM) state_nxt = MEM_WAIT;
      MEM_WAIT: if (hz.MemReadyM)                state_nxt = RUN;
      default:                                   state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        wait_cnt <= '0;
      end else begin
        if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
        // Set on the cycle whose increment reaches MAX_WAIT; sticky until reset.
        if (wait_cnt >= WW'(MAX_WAIT - 1)) timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      LoadStallCnt <= '0;
      RedirectCnt  <= '0;
      MemWaitCnt   <= '0;
    end else begin
      if (lu_resp && !(&LoadStallCnt)) LoadStallCnt <= LoadStallCnt + 1'b1;
      if (rd_resp && !(&RedirectCnt))  RedirectCnt  <= RedirectCnt + 1'b1;
      if (freeze  && !(&MemWaitCnt))   MemWaitCnt   <= MemWaitCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if hz();

`ifdef HAZARD_PERF_EN
  logic [31:0] lsc, rdc, mwc;
`endif

  hazard_unit #(.DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
`ifdef HAZARD_PERF_EN
    ,
    .LoadStallCnt(lsc),
    .RedirectCnt(rdc),
    .MemWaitCnt(mwc)
`endif
  );

  // Expected output word: {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, StallM,
  //                        FlushD, FlushE, FlushW, MemTimeout}
  localparam logic [11:0] E_NONE   = 12'b00_00_0000_000_0;
  localparam logic [11:0] E_RST    = 12'b00_00_0000_111_0;
  localparam logic [11:0] E_RST_TO = 12'b00_00_0000_111_1;
  localparam logic [11:0] E_FRZ    = 12'b00_00_1111_001_0;
  localparam logic [11:0] E_FRZ_TO = 12'b00_00_1111_001_1;
  localparam logic [11:0] E_LU     = 12'b00_00_1100_010_0;
  localparam logic [11:0] E_RD     = 12'b00_00_0000_110_0;
  localparam logic [11:0] E_FA_M   = 12'b10_00_0000_000_0;
  localparam logic [11:0] E_FA_W   = 12'b01_00_0000_000_0;
  localparam logic [11:0] E_FB_W   = 12'b00_01_0000_000_0;
  localparam logic [11:0] E_FAB_M  = 12'b10_10_0000_000_0;

  int n_vec = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushD, hz.FlushE, hz.FlushW, hz.MemTimeout};
  endfunction

  // Scoreboard: each driven vector's expectation is compared mid-cycle.
  always @(negedge clk)
    if (exp_q.size() != 0) chk(tag_q.pop_front(), {20'd0, obs()}, {20'd0, exp_q.pop_front()});

  task automatic idle();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.ResultSrcE = 1'b0; hz.PCSrcE = 1'b0;
    hz.RdM = '0; hz.RegWriteM = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    hz.RdW = '0; hz.RegWriteW = 1'b0;
  endtask

  task automatic step(input string tag, input logic [11:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  task automatic mem(input logic req, input logic rdy);
    hz.MemReqM = req; hz.MemReadyM = rdy;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;            // state now defined
    step("rst_out", E_RST);
    rst = 1'b0;

    // forwarding priority
    hz.Rs1E = 5; hz.RdM = 5; hz.RdW = 5; hz.RegWriteM = 1; hz.RegWriteW = 1;
    step("fwd_a_m", E_FA_M);
    hz.RegWriteM = 0;
    step("fwd_a_w", E_FA_W);
    hz.RegWriteM = 1; hz.Rs1E = 0; hz.RdM = 0; hz.RdW = 0;
    step("fwd_x0", E_NONE);
    idle(); hz.Rs2E = 9; hz.RdM = 9; hz.RdW = 9; hz.RegWriteW = 1;
    step("fwd_b_w", E_FB_W);
    idle(); hz.Rs1E = 12; hz.Rs2E = 12; hz.RdM = 12; hz.RegWriteM = 1; hz.RdW = 12; hz.RegWriteW = 1;
    step("fwd_ab_m", E_FAB_M);

    // load-use
    idle(); hz.ResultSrcE = 1; hz.RdE = 7; hz.Rs2D = 7;
    step("lu", E_LU);
    hz.ResultSrcE = 0;
    step("lu_clear", E_NONE);
    idle(); hz.ResultSrcE = 1; hz.RdE = 0; hz.Rs1D = 0;
    step("lu_x0", E_NONE);

    // redirect
    idle(); hz.ResultSrcE = 1; hz.RdE = 3; hz.Rs1D = 3; hz.PCSrcE = 1;
    step("lu_rd", E_RD);
    idle(); hz.PCSrcE = 1;
    step("rd", E_RD);

    // memory wait: 3 missed cycles then ready; LU/RD masked while frozen
    idle(); mem(1, 0);
    step("mw_enter", E_FRZ);
    hz.ResultSrcE = 1; hz.RdE = 7; hz.Rs2D = 7; hz.PCSrcE = 1;
    step("mw_mask", E_FRZ);
    idle(); mem(1, 0);
    step("mw_hold", E_FRZ);
    mem(1, 1);
    step("mw_release", E_FRZ);
    idle();
    step("mw_run", E_NONE);
    mem(1, 1);
    step("mw_hit", E_NONE);
    idle();
    step("mw_hit_run", E_NONE);

    // watchdog: ready held low for 6 cycles, then reset mid-wait
    mem(1, 0);
    for (int i = 0; i < 5; i++) step("wd_wait", E_FRZ);
    step("wd_trip", E_FRZ_TO);
    step("wd_sticky", E_FRZ_TO);
    rst = 1'b1;
    step("wd_rst", E_RST_TO);
    rst = 1'b0; idle();
    step("wd_after_rst", E_NONE);
    // counter restarted from 0: a 3-cycle wait must not trip the watchdog
    mem(1, 0);
    for (int i = 0; i < 3; i++) step("wd_recount", E_FRZ);
    mem(1, 1);
    step("wd_rel", E_FRZ);
    idle();
    step("wd_idle", E_NONE);

    // perf sequence: 2 LU, 1 RD, 3 freeze cycles
    rst = 1'b1;
    step("perf_rst", E_RST);
    rst = 1'b0;
    hz.ResultSrcE = 1; hz.RdE = 7; hz.Rs1D = 7;
    step("perf_lu1", E_LU);
    step("perf_lu2", E_LU);
    idle(); hz.PCSrcE = 1;
    step("perf_rd", E_RD);
    idle(); mem(1, 0);
    step("perf_mw1", E_FRZ);
    step("perf_mw2", E_FRZ);
    mem(1, 1);
    step("perf_mw3", E_FRZ);
    idle();
    step("perf_idle", E_NONE);

    repeat (2) @(negedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
`ifdef HAZARD_PERF_EN
    chk("load_stall_cnt", lsc, 2);
    chk("redirect_cnt", rdc, 1);
    chk("mem_wait_cnt", mwc, 3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
